// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_t   - deframer state encoding
//   PS2_DATA_BITS - data bits per device-to-host frame
//   PS2_BREAK     - scan-code set 2 break prefix
//   PS2_EXTEND    - scan-code set 2 extended prefix
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS = 8;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

endpackage

// File: rtl/ps2_frame_rx_filter.sv
// ps2_line_filter: 2-FF synchroniser followed by a stability filter for one
// raw PS/2 line.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   din  in  raw asynchronous line
//   dout out filtered level (resets to 1, the idle level of the bus)
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The output follows only after the synchronised value has disagreed with
  // it for FILTER_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      dout  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: conditions the raw PS/2 clock/data lines and deframes 11-bit
// device-to-host frames into a two-byte scan-code history.
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   kclk    in  raw PS/2 clock
//   kdata   in  raw PS/2 data
//   keycode out {previous byte, newest byte}
//   oflag   out one-cycle pulse, keycode just updated
//   err     out one-cycle pulse, frame dropped (start/parity/stop/timeout)
//
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in D0..D7, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, publishing the byte
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kclk,
  input  logic        kdata,
  output logic [15:0] keycode,
  output logic        oflag,
  output logic        err
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DATA   = DATA;
  localparam logic [1:0] S_PARITY = PARITY;
  localparam logic [1:0] S_STOP   = STOP;

  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(PS2_DATA_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic          kclk_f;
  logic          kdata_f;
  logic          kclk_prev;
  logic          strobe;
  logic [1:0]    state;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shreg;
  logic          par;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (kclk),
    .dout (kclk_f)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (kdata),
    .dout (kdata_f)
  );

  assign strobe = kclk_prev & ~kclk_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_prev <= 1'b1;
      state     <= S_IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      keycode   <= '0;
      oflag     <= 1'b0;
      err       <= 1'b0;
    end else begin
      kclk_prev <= kclk_f;
      oflag     <= 1'b0;
      err       <= 1'b0;
      // A strobe takes priority over a coincident timeout.
      if (strobe) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!kdata_f) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          S_DATA: begin
            shreg[bit_cnt] <= kdata_f;
            if (bit_cnt == BIT_LAST) state <= S_PARITY;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: begin
            par   <= kdata_f;
            state <= S_STOP;
          end
          default: begin
            if (kdata_f && (^{shreg, par})) begin
              keycode <= {keycode[7:0], shreg};
              oflag   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= S_IDLE;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TO_LAST) begin
          state   <= S_IDLE;
          bit_cnt <= '0;
          to_cnt  <= '0;
          err     <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule
